// File: rtl/uart_hex_tx_feeder_if.sv
// Handshake bundle between a word source, the hex feeder and the UART TX.
// master: the side that supplies words and tx_done_tick (source + UART TX).
// slave:  the hex feeder itself.
interface uart_hex_tx_feeder_if #(
   parameter int NIBBLES = 4
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [4*NIBBLES-1:0]   in_data;
   logic                   tx_start;
   logic [7:0]             tx_din;
   logic                   tx_done_tick;
   logic                   busy;

   modport master (
      output in_valid, in_data, tx_done_tick,
      input  in_ready, tx_start, tx_din, busy
   );

   modport slave (
      input  in_valid, in_data, tx_done_tick,
      output in_ready, tx_start, tx_din, busy
   );
endinterface

// File: rtl/uart_hex_tx_feeder.sv
// uart_hex_tx_feeder: converts each accepted word into ASCII hex characters,
// most-significant nibble first, and hands them one at a time to the UART TX
// (tx_start pulse, then wait for tx_done_tick).
// Optional feature: define UART_HEX_CRLF_EN to append CR (0x0D) and LF (0x0A)
// after the hex digits of every word.
module uart_hex_tx_feeder #(
   parameter int NIBBLES = 4,
   parameter bit UPPER   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   uart_hex_tx_feeder_if.slave     bus
);
   localparam int W = 4 * NIBBLES;
`ifdef UART_HEX_CRLF_EN
   localparam logic [3:0] LAST = 4'(NIBBLES + 1);
`else
   localparam logic [3:0] LAST = 4'(NIBBLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [W-1:0]   word_q, word_d;
   logic           in_ready_q, in_ready_d;
   logic           tx_start_q, tx_start_d;
   logic [7:0]     tx_din_q, tx_din_d;
   logic           busy_q, busy_d;

   // ASCII code of one hex digit; the case of A..F follows UPPER.
   function automatic logic [7:0] hex_char(input logic [3:0] v);
      logic [7:0] c;
      if (v < 4'd10) begin
         c = 8'h30 + {4'h0, v};
      end else if (UPPER) begin
         c = 8'h37 + {4'h0, v};
      end else begin
         c = 8'h57 + {4'h0, v};
      end
      return c;
   endfunction

   // Character at position idx of a word: digit idx is nibble NIBBLES-1-idx.
   function automatic logic [7:0] char_at(input logic [W-1:0] word, input logic [3:0] idx);
      logic [3:0] nib;
      logic [7:0] c;
      nib = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         nib = (idx == 4'(NIBBLES - 1 - i)) ? word[4*i +: 4] : nib;
      end
      c = hex_char(nib);
`ifdef UART_HEX_CRLF_EN
      if (idx == 4'(NIBBLES)) begin
         c = 8'h0D;
      end else if (idx == 4'(NIBBLES + 1)) begin
         c = 8'h0A;
      end else begin
         c = c;
      end
`endif
      return c;
   endfunction

   // Next-state and output logic; tx_din is loaded on the way into SEND so it
   // is already stable during the tx_start cycle and held through WAIT.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      in_ready_d = in_ready_q;
      tx_start_d = 1'b0;
      tx_din_d   = tx_din_q;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               word_d     = bus.in_data;
               cnt_d      = 4'd0;
               tx_din_d   = char_at(bus.in_data, 4'd0);
               tx_start_d = 1'b1;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = SEND;
            end else begin
               in_ready_d = 1'b1;
               busy_d     = 1'b0;
            end
         end
         SEND: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.tx_done_tick) begin
               if (cnt_q == LAST) begin
                  in_ready_d = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end else begin
                  cnt_d      = cnt_q + 4'd1;
                  tx_din_d   = char_at(word_q, cnt_q + 4'd1);
                  tx_start_d = 1'b1;
                  state_d    = SEND;
               end
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any word in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         word_q     <= '0;
         in_ready_q <= 1'b1;
         tx_start_q <= 1'b0;
         tx_din_q   <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         in_ready_q <= in_ready_d;
         tx_start_q <= tx_start_d;
         tx_din_q   <= tx_din_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_din   = tx_din_q;
   assign bus.busy     = busy_q;
endmodule
